seq_alu_param: RTL and testbench

- Parametrised sequential integer ALU; successor of the fixed 8-bit serial-load ALU.
- Operands are loaded in parallel on a single start strobe.
- Supports add, subtract, signed radix-2 Booth multiply and unsigned non-restoring divide at any WIDTH.
- Adds status flags, divide-error detection and back-to-back operation. Sits on the datapath bus as a start/busy/done slave.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_addsub.sv | 36 +++
 rtl/seq_alu_param.sv | 228 ++++++++++++++++++++++
 tb/tb_seq_alu_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential ALU. Holds the
//                operation encodings and the control FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select encodings (op port)
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Control FSM states, explicitly encoded
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : alu_addsub
//  Description : W-bit adder/subtractor. Computes i_a + i_b, or
//                i_a + ~i_b + 1 when i_sub is set.
//  Ports       : i_a, i_b  - operands (W bits)
//                i_sub     - 1 selects subtraction (also the carry-in)
//                o_sum     - W-bit result
//                o_cout    - carry out of the W-bit addition
//                o_ovf     - two's complement overflow of the W-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);

    logic [W-1:0] w_b;
    logic [W:0]   w_full;

    assign w_b    = i_b ^ {W{i_sub}};
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};

    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];
    // Overflow: both effective operands share a sign that the result lacks
    assign o_ovf  = (i_a[W-1] == w_b[W-1]) && (w_full[W-1] != i_a[W-1]);

endmodule : alu_addsub
`default_nettype wire

// File: rtl/seq_alu_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_param
//  Description : Parametrised sequential integer ALU with start/busy/done
//                handshake. add/sub complete in one iteration, signed Booth
//                multiply and unsigned non-restoring divide take WIDTH
//                iterations (divide adds one remainder-correction cycle).
//  Ports       : clk, rst (async, active-low), start, op[1:0],
//                x_hi/x_lo/y operands, busy/done status,
//                result_hi/result_lo, flag_c/v/z/dz/qo status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x_hi,
    input  logic [WIDTH-1:0] x_lo,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_dz,
    output logic             flag_qo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH:0]     r_a;     // Booth A (sign-extended) or divide partial remainder R
    logic [WIDTH-1:0]   r_q;     // Booth Q / divide quotient / add-sub first operand
    logic               r_qm1;   // Booth q_-1
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic               r_c;
    logic               r_v;
    logic               r_z;
    logic               r_dz;
    logic               r_qo;

    logic [WIDTH:0]     w_add_a;
    logic [WIDTH:0]     w_add_b;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH-1:0]   w_div_q;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(1));
    assign w_mul_lo = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_div_q  = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};

    // Operand steering for the single shared adder.
    // add/sub run in the upper WIDTH bits (LSB pads are zero) so the
    // adder's carry and overflow are exactly those of the WIDTH-bit op.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_sub   = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_add_a = {r_q, 1'b0};
                w_add_b = {r_y, 1'b0};
                w_sub   = (r_op == OP_SUB);
            end
            OP_MUL: begin
                // 10 -> A-M, 01 -> A+M, 00/11 -> A+0
                w_add_a = r_a;
                w_sub   = r_q[0] & ~r_qm1;
                w_add_b = (r_q[0] ^ r_qm1) ? {r_y[WIDTH-1], r_y} : '0;
            end
            default: begin
                if (r_state == S_CORR) begin
                    w_add_a = r_a;
                    w_add_b = {1'b0, r_y};
                    w_sub   = 1'b0;
                end else begin
                    // Shift {R,Q} left, then subtract y if R was
                    // non-negative before the shift, else add it.
                    w_add_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
                    w_add_b = {1'b0, r_y};
                    w_sub   = ~r_a[WIDTH];
                end
            end
        endcase
    end

    alu_addsub #(
        .W (WIDTH + 1)
    ) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_y      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_dz     <= 1'b0;
            r_qo     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_y     <= y;
                        r_q     <= x_lo;
                        r_qm1   <= 1'b0;
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                        r_z     <= 1'b0;
                        r_state <= S_ITER;
                        if (op == OP_DIV) begin
                            r_a  <= {1'b0, x_hi};
                            r_dz <= (y == '0);
                            r_qo <= (y != '0) && (x_hi >= y);
                            // Error cases bypass the iterations entirely
                            r_cnt <= ((y == '0) || (x_hi >= y)) ? CNT_W'(1) : CNT_W'(WIDTH);
                        end else begin
                            r_a   <= '0;
                            r_dz  <= 1'b0;
                            r_qo  <= 1'b0;
                            r_cnt <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(1);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_ITER: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (r_dz || r_qo) begin
                        // Divide error: operands are passed through unchanged
                        r_res_hi <= r_a[WIDTH-1:0];
                        r_res_lo <= r_q;
                        r_state  <= S_DONE;
                    end else begin
                        case (r_op)
                            OP_ADD, OP_SUB: begin
                                r_res_hi <= '0;
                                r_res_lo <= w_sum[WIDTH:1];
                                r_c      <= w_cout;
                                r_v      <= w_ovf;
                                r_z      <= (w_sum[WIDTH:1] == '0);
                                r_state  <= S_DONE;
                            end
                            OP_MUL: begin
                                // Arithmetic shift right of {A,Q,q_-1}
                                r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                                r_q   <= w_mul_lo;
                                r_qm1 <= r_q[0];
                                if (w_last) begin
                                    r_res_hi <= w_sum[WIDTH:1];
                                    r_res_lo <= w_mul_lo;
                                    r_z      <= ({w_sum[WIDTH:1], w_mul_lo} == '0);
                                    r_state  <= S_DONE;
                                end
                            end
                            default: begin
                                r_a <= w_sum;
                                r_q <= w_div_q;
                                if (w_last) begin
                                    r_state <= S_CORR;
                                end
                            end
                        endcase
                    end
                end

                S_CORR: begin
                    // Negative partial remainder is restored by adding y back
                    r_res_hi <= r_a[WIDTH] ? w_sum[WIDTH-1:0] : r_a[WIDTH-1:0];
                    r_res_lo <= r_q;
                    r_z      <= (r_q == '0);
                    r_state  <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_ITER) || (r_state == S_CORR);
    assign done      = (r_state == S_DONE);
    assign result_hi = r_res_hi;
    assign result_lo = r_res_lo;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_z    = r_z;
    assign flag_dz   = r_dz;
    assign flag_qo   = r_qo;

endmodule : seq_alu_param
`default_nettype wire

// File: tb/tb_seq_alu_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu_param
//  Description : Directed self-checking bench for seq_alu_param at WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu_param;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] x_hi  = '0;
    logic [W-1:0] x_lo  = '0;
    logic [W-1:0] y     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_dz;
    logic         flag_qo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu_param #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .x_hi      (x_hi),
        .x_lo      (x_lo),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_dz   (flag_dz),
        .flag_qo   (flag_qo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, result_hi, result_lo,
                    flag_c, flag_v, flag_z, flag_dz, flag_qo});
    endfunction

    function automatic logic [31:0] flags5();
        return 32'({flag_c, flag_v, flag_z, flag_dz, flag_qo});
    endfunction

    // Called #1 after the accepting edge; returns edges until done and
    // the number of sampled busy cycles. Bounded so a stuck DUT cannot hang.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] xh, input logic [W-1:0] xl,
                          input logic [W-1:0] yy, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        x_hi  = xh;
        x_lo  = xl;
        y     = yy;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        int seen;

        // Reset held with start asserted: start must be ignored
        rst   = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        x_lo  = 8'd1;
        y     = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", all_outs(), 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 32'h0);

        // add 40+12
        run_op(2'b00, 8'h00, 8'd40, 8'd12, lat, bc);
        check("add_lat", 32'(lat), 1);
        check("add_busy", 32'(bc), 1);
        check("add_lo", 32'(result_lo), 52);
        check("add_hi", 32'(result_hi), 0);
        check("add_flags", flags5(), 0);
        @(posedge clk);
        #1;
        check("add_done_1cyc", 32'(done), 0);

        // sub 12-40
        run_op(2'b01, 8'h00, 8'd12, 8'd40, lat, bc);
        check("sub1_lo", 32'(result_lo), 32'hE4);
        check("sub1_flags", flags5(), 0);

        // sub 100-(-100): signed overflow
        run_op(2'b01, 8'h00, 8'd100, 8'h9C, lat, bc);
        check("sub2_lo", 32'(result_lo), 32'hC8);
        check("sub2_flags", flags5(), 32'b01000);

        // add 0x80+0x80: carry, overflow and zero together
        run_op(2'b00, 8'h00, 8'h80, 8'h80, lat, bc);
        check("add_wrap_lo", 32'(result_lo), 0);
        check("add_wrap_flags", flags5(), 32'b11100);

        // mul 40*12
        run_op(2'b10, 8'h00, 8'd40, 8'd12, lat, bc);
        check("mul1_lat", 32'(lat), 8);
        check("mul1_busy", 32'(bc), 8);
        check("mul1_prod", 32'({result_hi, result_lo}), 32'h01E0);
        check("mul1_flags", flags5(), 0);

        // mul -3*5
        run_op(2'b10, 8'h00, 8'hFD, 8'h05, lat, bc);
        check("mul2_prod", 32'({result_hi, result_lo}), 32'hFFF1);

        // div 0x2D16 / 135 = 85 r 67
        run_op(2'b11, 8'h2D, 8'h16, 8'd135, lat, bc);
        check("div_lat", 32'(lat), 9);
        check("div_busy", 32'(bc), 9);
        check("div_q", 32'(result_lo), 85);
        check("div_r", 32'(result_hi), 67);
        check("div_flags", flags5(), 0);

        // div by zero
        run_op(2'b11, 8'h12, 8'h34, 8'h00, lat, bc);
        check("dz_lat", 32'(lat), 1);
        check("dz_flags", flags5(), 32'b00010);
        check("dz_res", 32'({result_hi, result_lo}), 32'h1234);

        // quotient overflow x_hi >= y
        run_op(2'b11, 8'd200, 8'h05, 8'd135, lat, bc);
        check("qo_lat", 32'(lat), 1);
        check("qo_flags", flags5(), 32'b00001);
        check("qo_res", 32'({result_hi, result_lo}), 32'hC805);

        // Reset in the 4th ITER cycle of a mul
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        x_lo  = 8'd40;
        y     = 8'd12;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_outs", all_outs(), 32'h0);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'b00, 8'h00, 8'd1, 8'd1, lat, bc);
        check("post_rst_add", 32'(result_lo), 2);
        check("post_rst_lat", 32'(lat), 1);

        // Back-to-back: new mul started in the DONE cycle of an add
        run_op(2'b00, 8'h00, 8'd5, 8'd6, lat, bc);
        check("b2b_add_lo", 32'(result_lo), 11);
        start = 1'b1;
        op    = 2'b10;
        x_lo  = 8'd3;
        y     = 8'hFE;
        @(posedge clk);
        #1;
        check("b2b_accept", 32'({busy, done}), 32'b10);
        // start during busy must be ignored
        op   = 2'b00;
        x_lo = 8'd1;
        y    = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("b2b_mul_lat", 32'(lat + 1), 8);
        check("b2b_mul_prod", 32'({result_hi, result_lo}), 32'hFFFA);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("b2b_no_queue", 32'(seen), 0);
        check("b2b_hold", 32'({result_hi, result_lo}), 32'hFFFA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_alu_param
`default_nettype wire
